// File: rtl/game_pkg.sv
// Shared widths and types for the two-lane rhythm-game core.
package game_pkg;
  localparam int LANE_W    = 8;
  localparam int PATTERN_W = 32;
  localparam int IDX_W     = 5;
  localparam int DIFF_W    = 23;
  localparam int CNT_W     = 8;

  typedef logic [LANE_W-1:0] lane_t;
endpackage

// File: rtl/note_lane.sv
// One scrolling note lane: window, button edge detect, per-cycle hit/miss flags.
// Empty presses count as misses when GAME_EMPTY_PRESS_MISS_EN is defined.
module note_lane
  import game_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  tick,
  input  logic  note_in,
  input  logic  button,
  output lane_t window,
  output logic  hit,
  output logic  miss
);

  lane_t win_p0;
  logic  prev_p0;
  logic  press;

  assign press  = button & ~prev_p0;
  assign window = win_p0;

  always_comb begin
    hit = press & win_p0[0];
`ifdef GAME_EMPTY_PRESS_MISS_EN
    miss = press ? ~win_p0[0] : (tick & win_p0[0]);
`else
    miss = ~press & tick & win_p0[0];
`endif
  end

  // stage p0: window and previous button level
  always_ff @(posedge clk) begin
    if (rst) begin
      win_p0  <= '0;
      prev_p0 <= 1'b0;
    end else begin
      prev_p0 <= button;
      // A hit note is discarded by the shift anyway, so tick wins over the clear.
      if (tick)
        win_p0 <= {note_in, win_p0[LANE_W-1:1]};
      else if (hit)
        win_p0[0] <= 1'b0;
    end
  end

endmodule

// File: rtl/main_game_ctrl.sv
// Two-lane rhythm-game core: tick generator, pattern index, saturating score counters.
// Optional macro GAME_EMPTY_PRESS_MISS_EN (in note_lane) penalises empty presses.
module main_game_ctrl
  import game_pkg::*;
(
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [PATTERN_W-1:0] notes1,
  input  logic [PATTERN_W-1:0] notes2,
  input  logic [DIFF_W-1:0]    diff,
  input  logic                 button_1,
  input  logic                 button_2,
  output logic [2*LANE_W-1:0]  out,
  output logic [CNT_W-1:0]     num_hits,
  output logic [CNT_W-1:0]     num_misses
);

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                              input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  logic [DIFF_W-1:0] tcnt_p0;
  logic [IDX_W-1:0]  idx_p0;
  logic [IDX_W-1:0]  sel;
  logic [CNT_W-1:0]  hits_p0;
  logic [CNT_W-1:0]  misses_p0;
  logic              tick;
  logic              hit1, hit2, miss1, miss2;
  lane_t             w1, w2;
  logic [1:0]        hit_sum, miss_sum;

  assign tick     = (tcnt_p0 == diff);
  // Bit 31 plays first, so the index counts down through the pattern.
  assign sel      = IDX_W'(PATTERN_W-1) - idx_p0;
  assign hit_sum  = {1'b0, hit1} + {1'b0, hit2};
  assign miss_sum = {1'b0, miss1} + {1'b0, miss2};

  note_lane u_lane1 (
    .clk(clk), .rst(n_rst), .tick(tick), .note_in(notes1[sel]),
    .button(button_1), .window(w1), .hit(hit1), .miss(miss1)
  );

  note_lane u_lane2 (
    .clk(clk), .rst(n_rst), .tick(tick), .note_in(notes2[sel]),
    .button(button_2), .window(w2), .hit(hit2), .miss(miss2)
  );

  // stage p0: tick counter, pattern index, score counters
  always_ff @(posedge clk) begin
    if (n_rst) begin
      tcnt_p0   <= '0;
      idx_p0    <= '0;
      hits_p0   <= '0;
      misses_p0 <= '0;
    end else begin
      tcnt_p0   <= tick ? '0 : tcnt_p0 + 1'b1;
      if (tick)
        idx_p0 <= idx_p0 + 1'b1;
      hits_p0   <= sat_add(hits_p0, hit_sum);
      misses_p0 <= sat_add(misses_p0, miss_sum);
    end
  end

  assign out        = {w2, w1};
  assign num_hits   = hits_p0;
  assign num_misses = misses_p0;

endmodule

// File: tb/tb_main_game_ctrl.sv
// Scoreboard bench for main_game_ctrl: a lane-level reference model queues expected outputs per edge.
module tb_main_game_ctrl;

  typedef struct packed {
    logic [15:0] out;
    logic [7:0]  hits;
    logic [7:0]  misses;
  } exp_t;

`ifdef GAME_EMPTY_PRESS_MISS_EN
  localparam int EMPTY_MISS = 1;
`else
  localparam int EMPTY_MISS = 0;
`endif

  logic        clk = 1'b0;
  logic        n_rst;
  logic [31:0] notes1, notes2;
  logic [22:0] diff;
  logic        button_1, button_2;
  logic [15:0] out;
  logic [7:0]  num_hits, num_misses;

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  exp_t exp_q[$];

  // reference model state
  int m_tcnt, m_idx, m_ticks, m_hits, m_misses;
  bit m_prev[2];
  bit m_win[2][8];   // [lane][position], position 0 is the hit zone

  main_game_ctrl dut (
    .clk(clk), .n_rst(n_rst), .notes1(notes1), .notes2(notes2), .diff(diff),
    .button_1(button_1), .button_2(button_2), .out(out),
    .num_hits(num_hits), .num_misses(num_misses)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cycle, act, req);
    end
  endtask

  task automatic model_step();
    exp_t e;
    bit btn[2];
    logic [31:0] pat[2];
    bit tk, press;
    int h, m;
    btn[0] = button_1; btn[1] = button_2;
    pat[0] = notes1;   pat[1] = notes2;
    if (n_rst) begin
      m_tcnt = 0; m_idx = 0; m_ticks = 0; m_hits = 0; m_misses = 0;
      for (int l = 0; l < 2; l++) begin
        m_prev[l] = 0;
        for (int i = 0; i < 8; i++) m_win[l][i] = 0;
      end
    end else begin
      tk = (m_tcnt == int'(diff));
      h = 0; m = 0;
      for (int l = 0; l < 2; l++) begin
        press = btn[l] && !m_prev[l];
        if (press && m_win[l][0]) begin
          h++;
          m_win[l][0] = 0;
        end else if (press) begin
          m += EMPTY_MISS;
        end else if (tk && m_win[l][0]) begin
          m++;
        end
        m_prev[l] = btn[l];
      end
      if (tk) begin
        for (int l = 0; l < 2; l++) begin
          for (int i = 0; i < 7; i++) m_win[l][i] = m_win[l][i+1];
          m_win[l][7] = pat[l][31 - m_idx];
        end
        m_idx = (m_idx + 1) % 32;
        m_ticks++;
        m_tcnt = 0;
      end else begin
        m_tcnt++;
      end
      m_hits = (m_hits + h > 255) ? 255 : m_hits + h;
      m_misses = (m_misses + m > 255) ? 255 : m_misses + m;
    end
    for (int l = 0; l < 2; l++)
      for (int i = 0; i < 8; i++) e.out[l*8 + i] = m_win[l][i];
    e.hits = 8'(m_hits);
    e.misses = 8'(m_misses);
    exp_q.push_back(e);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    n_rst = 1'b1;
    step();
    step();
    n_rst = 1'b0;
  endtask

  task automatic run_to_tick(input int target, output int steps);
    steps = 0;
    while (m_ticks < target && steps < 20000) begin
      step();
      steps++;
    end
    if (m_ticks < target) begin
      failures++;
      $display("FAIL tick_timeout cycle=%0d actual=%0d required=%0d", cycle, m_ticks, target);
    end
  endtask

  // monitor: one expected record per clock edge
  exp_t got;
  always @(posedge clk) begin
    cycle++;
    #1;
    if (exp_q.size() > 0) begin
      got = exp_q.pop_front();
      chk("sb_out", 32'(out), 32'(got.out));
      chk("sb_hits", 32'(num_hits), 32'(got.hits));
      chk("sb_misses", 32'(num_misses), 32'(got.misses));
    end
  end

  initial begin
    int n;
    n_rst = 1'b1; button_1 = 0; button_2 = 0;
    diff = 23'd99; notes1 = 32'hAAAAAAAA; notes2 = 32'hCCCCCCCC;
    do_reset();
    chk("reset_out", 32'(out), 0);
    chk("reset_counts", {16'h0, num_hits, num_misses}, 0);

    // idle scroll
    run_to_tick(1, n);
    chk("first_tick_latency", n, 100);
    chk("tick1_out", 32'(out), 32'h8080);
    run_to_tick(8, n);
    chk("tick8_out", 32'(out), 32'h3355);
    run_to_tick(9, n);
    chk("tick9_misses", 32'(num_misses), 2);
    chk("tick9_hits", 32'(num_hits), 0);

    // single pulse on both lanes while notes sit in the zone
    do_reset();
    run_to_tick(8, n);
    repeat (10) step();
    button_1 = 1; button_2 = 1;
    step();
    chk("zone_cleared", {30'h0, out[8], out[0]}, 0);
    button_1 = 0; button_2 = 0;
    run_to_tick(9, n);
    chk("pulse_hits", 32'(num_hits), 2);
    chk("pulse_misses", 32'(num_misses), 0);

    // buttons held across three ticks
    do_reset();
    run_to_tick(8, n);
    button_1 = 1; button_2 = 1;
    run_to_tick(11, n);
    button_1 = 0; button_2 = 0;
    step();
    chk("hold_hits", 32'(num_hits), 2);
    chk("hold_misses", 32'(num_misses), 2);

    // press with empty hit zone
    do_reset();
    run_to_tick(2, n);
    button_1 = 1;
    step();
    button_1 = 0;
    step();
    chk("empty_press_misses", 32'(num_misses), EMPTY_MISS);
    chk("empty_press_hits", 32'(num_hits), 0);

    // fastest scroll with every note present saturates the miss counter
    diff = 23'd0; notes1 = 32'hFFFFFFFF; notes2 = 32'hFFFFFFFF;
    do_reset();
    run_to_tick(9, n);
    chk("fast_tick9_misses", 32'(num_misses), 2);
    repeat (200) step();
    chk("fast_sat_misses", 32'(num_misses), 255);

    // reset in the middle of a song
    diff = 23'd3; notes1 = 32'hAAAAAAAA; notes2 = 32'hCCCCCCCC;
    do_reset();
    run_to_tick(10, n);
    n_rst = 1'b1;
    step();
    chk("midrst_out", 32'(out), 0);
    chk("midrst_counts", {16'h0, num_hits, num_misses}, 0);
    n_rst = 1'b0;
    run_to_tick(1, n);
    chk("midrst_restart", 32'(out), 32'h8080);

    // randomized play
    for (int seg = 0; seg < 6; seg++) begin
      diff = 23'($urandom_range(0, 6));
      notes1 = $urandom;
      notes2 = $urandom;
      for (int c = 0; c < 500; c++) begin
        n_rst = ($urandom_range(0, 399) == 0);
        if ($urandom_range(0, 3) == 0) button_1 = $urandom_range(0, 1);
        if ($urandom_range(0, 3) == 0) button_2 = $urandom_range(0, 1);
        step();
      end
    end
    n_rst = 1'b0; button_1 = 0; button_2 = 0;
    step();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/main_game_ctrl.md
# main_game_ctrl

Two-lane rhythm-game core for the guitar game. Two 32-bit note patterns scroll through 8-position lane windows at a rate set by `diff`. Button presses are scored against the note sitting in each lane's hit zone, and the block keeps saturating hit and miss counters. It sits between the song/difficulty source and the LED display and score logic; the RTL module is `main_game_ctrl`.

## Interface
- No parameters; all widths come from the shared package.
- `clk` input 1: the single system clock, rising-edge.
- `n_rst` input 1: synchronous, active-high reset. When it is 1 at a rising `clk` edge, all state clears. The port keeps the codebase name.
- `notes1` input 32: lane-1 note pattern; bit 31 plays first.
- `notes2` input 32: lane-2 note pattern; bit 31 plays first.
- `diff` input 23: scroll period minus 1, in clocks. Sampled live.
- `button_1` input 1: lane-1 fret button, synchronous level.
- `button_2` input 1: lane-2 fret button, synchronous level.
- `out` output 16: display. `out[15:8]` is lane-2 window `w2`; `out[7:0]` is lane-1 window `w1`. Bit 0 of each lane is the hit zone.
- `num_hits` output 8: saturating hit count.
- `num_misses` output 8: saturating miss count.

## Operation
- **Tick generator:** 23-bit counter `tcnt`.
  - When `tcnt == diff`, `tick` is asserted and `tcnt` returns to 0; otherwise `tcnt` increments.
  - With `diff = 0`, tick fires every cycle.
- **Pattern index:** 5-bit `idx` advances by 1 on each tick and wraps 31→0, so the song repeats.
- **Scroll on tick:** `wN <= {notesN[31-idx], wN[7:1]}`. The new note enters at bit 7; bit 0 leaves the window.
- **Edge detect:** per lane, `prevN <= buttonN` and `pressN = buttonN & ~prevN`. Only rising edges score; holding a button does nothing further.
- **Per-lane scoring:** each lane raises at most one event per cycle.
  - `pressN` and `wN[0] = 1`: hit. `wN[0]` is cleared in the same update, so the note cannot also count as a miss.
  - `pressN` and `wN[0] = 0`: empty press; handling depends on the macro in Configuration.
  - `tick` and `wN[0] = 1` with no `pressN`: the unhit note leaves the window and counts as a miss.
- **Same-cycle press and tick:** the hit is evaluated first, then the window shifts. Hit zone cleared by the hit, no miss.
- **Counters:** each cycle, `num_hits` adds the number of hits (0–2) and `num_misses` adds the number of misses (0–2). Both saturate at 255 and never wrap.
- **Reset values:** `w1`, `w2`, `idx`, `tcnt`, `prev1`, `prev2`, `num_hits` and `num_misses` are all 0, so `out = 16'h0000`.
- **Reset mid-song:** all state clears on that edge; the song restarts at bit 31 when `n_rst` is released.

## Timing
- All outputs are registered. An event in cycle n appears on the outputs after the edge ending cycle n.
- **First tick:** with `diff = D` and reset released before edge 0, the first tick occurs on edge D (D+1 clocks per tick).
- **Press latency:** a press is scored on the same edge that samples the rising level. Counters update on that edge.
- **Note travel:** a note first appears at bit 7 and reaches bit 0 seven ticks later. It stays in the hit zone for one tick period.

## Configuration
- **Macro `GAME_EMPTY_PRESS_MISS_EN`:**
  - Defined: a press with `wN[0] = 0` increments `num_misses` (anti-button-mash penalty).
  - Undefined: such presses are ignored.

## Structure
- **Package `game_pkg`:**
  - Constants: `LANE_W = 8`, `PATTERN_W = 32`, `IDX_W = 5`, `DIFF_W = 23`, `CNT_W = 8`.
  - Typedef `lane_t` (`logic [LANE_W-1:0]`).
- **Sub-module `note_lane`:** instantiated twice. It holds the window, edge detect and per-lane hit/miss flags.
- **Top level:** owns the tick generator, `idx` and the saturating counters.

## Test plan
- `diff = 99`, `notes1 = 32'hAAAAAAAA`, `notes2 = 32'hCCCCCCCC`, no presses, after reset:
  - Tick 1 at clock 100: `out = 16'h8080`.
  - Tick 8: `out = 16'h3355`.
  - Tick 9: `num_misses = 2`, `num_hits = 0`.
- Same setup, pulse both buttons for 1 cycle between tick 8 and tick 9 → `num_hits = 2`, `num_misses = 0` after tick 9. Hit-zone bits read 0 after the press.
- Hold both buttons high for 3 ticks starting at tick 8 → only 2 hits are counted. The tick-9 and tick-10 notes that reach the zone are scored as misses.
- Press lane 1 while `w1[0] = 0` → `num_misses` goes +1 with `GAME_EMPTY_PRESS_MISS_EN` defined, +0 without it.
- `diff = 0`, all-ones patterns, no presses → `num_misses` climbs by 2 per clock from tick 8 onward and holds at 255.
- Assert `n_rst` mid-song with `out ≠ 0` → next cycle `out`, `num_hits` and `num_misses` are all 0. After release, the first tick loads `notes[31]` again.
